ctrl_sequencer: RTL and testbench
=================================

# ctrl_sequencer

Multi-cycle control sequencer for the 8-bit basic processor: it fetches 9-bit instructions from instruction memory over a req/ack handshake, decodes them, and drives the combinational ALU's opcode, immediate, and register-file read/write controls. It also consumes the ALU `Branch` flag to update the program counter. It sits between instruction memory, the register file, and the ALU, and owns the PC.

## Interface
- `PC_W`, 10: program counter / instruction address width.

Ports:
- `Clk`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Start`  in  1  one-cycle pulse; begins execution at PC=0.
- `ImemReq`  out  PC_W→1  fetch request; held until acknowledged.
- `ImemAddr`  out  PC_W  fetch address, equal to the PC.
- `ImemAck`  in  1  fetch acknowledge; `ImemData` is valid in the same cycle.
- `ImemData`  in  9  instruction word.
- `AluOp`  out  4  ALU opcode, `Instr[8:5]`.
- `AluIm`  out  3  ALU immediate, `Instr[2:0]`.
- `RdAddr`  out  2  register-file read port A address and write address, `Instr[4:3]`.
- `RsAddr`  out  2  register-file read port B address, `Instr[1:0]`.
- `AluBranch`  in  1  ALU branch flag.
- `RegWrEn`  out  1  register-file write enable; the write address is `RdAddr` and the data is the ALU output.
- `Pc`  out  PC_W  current program counter.
- `Done`  out  1  high while halted.

## Operation
- States:
  - IDLE: after reset.
  - FETCH
  - EXEC
  - HALTED
- IDLE: all outputs are 0. `Start` sets PC=0 and moves to FETCH.
- FETCH:
  - `ImemReq`=1 and `ImemAddr`=PC.
  - On a cycle with `ImemAck`=1, `ImemData` is latched into the instruction register (IR) and the state moves to EXEC.
  - Without an ack, FETCH holds indefinitely.
- EXEC (exactly one cycle): `AluOp`, `AluIm`, `RdAddr` and `RsAddr` are driven from IR. The action depends on the opcode:
  - ADD=0, ADDI=1, LSH=2, RSH=3, AND=4, OR=5, NEG=6, GEQ=7, EQ=8, NEQ=9: `RegWrEn`=1, PC←PC+1, next state FETCH.
  - BNZ=10: `RegWrEn`=0. If `AluBranch`=1, PC←PC+sext(`Im`) (offset range −4..+3); otherwise PC←PC+1. Next state FETCH.
  - HALT=15: `RegWrEn`=0, PC unchanged, next state HALTED.
  - 11–14 (reserved): no-op. `RegWrEn`=0, PC←PC+1, next state FETCH.
- HALTED: `Done`=1 and all other control outputs are 0. `Start` clears `Done`, sets PC=0 and moves to FETCH.
- Outside EXEC, `AluOp`, `AluIm`, `RdAddr`, `RsAddr` and `RegWrEn` are all 0.
- PC arithmetic is modulo 2^PC_W:
  - increment past 2^PC_W−1 wraps to 0;
  - a negative offset below 0 wraps to the top.
- A BNZ offset of 0 with the branch taken re-executes the same instruction. This is legal and is the sanctioned spin idiom.

## Timing
- Reset is asynchronous and active-low. While asserted:
  - state=IDLE, PC=0, IR=0;
  - `ImemReq`, `RegWrEn` and `Done` are 0;
  - all buses are 0.
- `ImemReq` falls in the same cycle as the assertion, not at the next edge.
- A zero-wait memory acks in the first FETCH cycle, giving 2 cycles per instruction. Each wait cycle adds 1.
- `ImemAck` is ignored outside FETCH.
- `Start` is ignored in FETCH and EXEC.
- `Start` and `Reset` together: reset wins.
- `RegWrEn` is active only during the single EXEC cycle. The register file captures the write on the edge that ends EXEC.
- `AluBranch` is sampled only in EXEC of a BNZ instruction.
- The PC update and the next `ImemAddr` both take effect on the edge that ends EXEC.
- `Pc` is registered and changes only at the end of EXEC, or on `Start`.

## Structure
- Shared package `definitions` holds:
  - the 4-bit opcode enum with the values above, including HALT=4'hF and reserved codes 11–14;
  - the sequencer state enum;
  - the instruction field slice constants.
- Sub-module `instr_decode` is combinational: it maps IR to the ALU and register controls, `is_write`, `is_branch` and `is_halt`. The FSM and PC live in `ctrl_sequencer`.

## Test plan
- **Basic fetch and write.** Reset low then high, `Start` pulse, zero-wait memory, PC0=ADDI r1 #3 (9'b0001_01_011). Required: `ImemAddr`=0 in cycle 1; EXEC in cycle 2 with `AluOp`=1, `AluIm`=3, `RdAddr`=1, `RegWrEn`=1; then PC=1.
- **Memory wait states.** Ack delayed 3 cycles. Required: `ImemReq` held high for 4 cycles with `ImemAddr` stable; exactly one EXEC follows.
- **BNZ taken and not taken.** BNZ at PC=5 with `Im`=3'b110 (−2). With `AluBranch`=1, the next `ImemAddr` is 3. With `AluBranch`=0, the next `ImemAddr` is 6. `RegWrEn` stays 0 in both cases.
- **Wrap-around and reserved opcode.** Reserved opcode 12 at PC=1023 (PC_W=10). Required: no write and next PC=0. Also, BNZ with −4 taken at PC=1 gives PC=1021.
- **Halt and restart.** HALT at PC=2. Required: `Done`=1 and `ImemReq`=0. `ImemAck` pulses while halted are ignored. A `Start` pulse clears `Done` and fetches address 0.
- **Reset mid-fetch.** Assert reset mid-fetch with `ImemReq`=1. Required: `ImemReq` drops before the next edge, PC=0, and the state returns to IDLE.

Source files
------------

// File: rtl/ctrl_sequencer_pkg.sv
// Shared definitions for the basic-processor control sequencer.
// Contents:
//   opcode_e        - the 4-bit ALU/control opcode set, including the
//                     reserved codes 11..14 and HALT = 4'hF
//   ST_*            - sequencer state encodings (IDLE/FETCH/EXEC/HALTED)
//   INSTR_W, *_MSB/*_LSB - instruction word width and field slice positions
//   is_reg_write()  - opcodes that write the register file
package definitions;

  // Opcode set; 11..14 are reserved and behave as no-ops.
  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_ADDI  = 4'd1,
    OP_LSH   = 4'd2,
    OP_RSH   = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_NEG   = 4'd6,
    OP_GEQ   = 4'd7,
    OP_EQ    = 4'd8,
    OP_NEQ   = 4'd9,
    OP_BNZ   = 4'd10,
    OP_RSV11 = 4'd11,
    OP_RSV12 = 4'd12,
    OP_RSV13 = 4'd13,
    OP_RSV14 = 4'd14,
    OP_HALT  = 4'hF
  } opcode_e;

  // Sequencer states, kept as plain constants for legacy tooling.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_EXEC   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  // Instruction word layout: op[8:5] rd[4:3] im[2:0], with rs overlapping im[1:0].
  localparam int INSTR_W = 9;
  localparam int OP_MSB  = 8;
  localparam int OP_LSB  = 5;
  localparam int RD_MSB  = 4;
  localparam int RD_LSB  = 3;
  localparam int IM_MSB  = 2;
  localparam int IM_LSB  = 0;
  localparam int RS_MSB  = 1;
  localparam int RS_LSB  = 0;

  // Only the ALU operations (ADD..NEQ) produce a register-file write.
  function automatic logic is_reg_write(input opcode_e op);
    return (op <= OP_NEQ);
  endfunction

endpackage

// File: rtl/ctrl_sequencer_decode.sv
// instr_decode: purely combinational decode of the instruction register.
// Ports:
//   ir        in   INSTR_W  latched instruction word
//   alu_op    out  4        opcode field
//   alu_im    out  3        immediate field
//   rd_addr   out  2        destination / read-port-A register
//   rs_addr   out  2        read-port-B register (shares bits with alu_im)
//   is_write  out  1        instruction writes the register file
//   is_branch out  1        instruction is BNZ
//   is_halt   out  1        instruction is HALT
module instr_decode
  import definitions::*;
(
  input  logic [INSTR_W-1:0] ir,
  output logic [3:0]         alu_op,
  output logic [2:0]         alu_im,
  output logic [1:0]         rd_addr,
  output logic [1:0]         rs_addr,
  output logic               is_write,
  output logic               is_branch,
  output logic               is_halt
);

  opcode_e op;

  assign op      = opcode_e'(ir[OP_MSB:OP_LSB]);
  assign alu_op  = ir[OP_MSB:OP_LSB];
  assign alu_im  = ir[IM_MSB:IM_LSB];
  assign rd_addr = ir[RD_MSB:RD_LSB];
  assign rs_addr = ir[RS_MSB:RS_LSB];

  // Classify the opcode; reserved codes fall through with all flags low.
  always_comb begin
    is_write  = is_reg_write(op);
    is_branch = (op == OP_BNZ);
    is_halt   = (op == OP_HALT);
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle fetch/execute control for the 8-bit processor.
// Owns the PC and the instruction register, fetches over a req/ack handshake
// and drives ALU / register-file controls for one EXEC cycle per instruction.
// Ports:
//   Clk, Reset       clock; asynchronous active-low reset
//   Start            pulse that starts execution at PC=0 (from IDLE or HALTED)
//   ImemReq/Addr     fetch request and address (address is always the PC)
//   ImemAck/Data     fetch acknowledge with same-cycle instruction data
//   AluOp/AluIm      ALU opcode and immediate (non-zero only in EXEC)
//   RdAddr/RsAddr    register-file addresses (non-zero only in EXEC)
//   AluBranch        ALU branch flag, used only by BNZ in EXEC
//   RegWrEn          register-file write strobe, EXEC only
//   Pc               registered program counter
//   Done             high while halted
module ctrl_sequencer
  import definitions::*;
#(
  parameter int PC_W = 10
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  output logic               ImemReq,
  output logic [PC_W-1:0]    ImemAddr,
  input  logic               ImemAck,
  input  logic [INSTR_W-1:0] ImemData,
  output logic [3:0]         AluOp,
  output logic [2:0]         AluIm,
  output logic [1:0]         RdAddr,
  output logic [1:0]         RsAddr,
  input  logic               AluBranch,
  output logic               RegWrEn,
  output logic [PC_W-1:0]    Pc,
  output logic               Done
);

  logic [1:0]         state, state_next;
  logic [PC_W-1:0]    pc, pc_next;
  logic [INSTR_W-1:0] ir;

  logic [3:0] dec_op;
  logic [2:0] dec_im;
  logic [1:0] dec_rd, dec_rs;
  logic       dec_write, dec_branch, dec_halt;
  logic       in_exec;
  logic [PC_W-1:0] branch_offset;

  instr_decode u_decode (
    .ir        (ir),
    .alu_op    (dec_op),
    .alu_im    (dec_im),
    .rd_addr   (dec_rd),
    .rs_addr   (dec_rs),
    .is_write  (dec_write),
    .is_branch (dec_branch),
    .is_halt   (dec_halt)
  );

  // Sign-extend the 3-bit immediate so PC arithmetic wraps naturally mod 2^PC_W.
  assign branch_offset = {{(PC_W-3){dec_im[2]}}, dec_im};

  // Next-state and next-PC logic. The PC only moves on Start or at the end
  // of EXEC; HALT leaves it pointing at the HALT instruction.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    case (state)
      ST_IDLE, ST_HALTED: begin
        if (Start) begin
          state_next = ST_FETCH;
          pc_next    = '0;
        end
      end
      ST_FETCH: begin
        if (ImemAck) state_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (dec_halt) begin
          state_next = ST_HALTED;
        end else begin
          state_next = ST_FETCH;
          pc_next    = (dec_branch && AluBranch) ? pc + branch_offset
                                                 : pc + PC_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and PC registers; reset drops everything back to IDLE at PC 0.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= ST_IDLE;
      pc    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // The instruction register captures memory data only on an acked fetch.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ir <= '0;
    end else if (state == ST_FETCH && ImemAck) begin
      ir <= ImemData;
    end
  end

  // Outputs decode straight from state so ImemReq drops as soon as reset
  // is asserted, without waiting for a clock edge.
  assign in_exec  = (state == ST_EXEC);
  assign ImemReq  = (state == ST_FETCH);
  assign ImemAddr = pc;
  assign Pc       = pc;
  assign Done     = (state == ST_HALTED);
  assign AluOp    = in_exec ? dec_op : 4'd0;
  assign AluIm    = in_exec ? dec_im : 3'd0;
  assign RdAddr   = in_exec ? dec_rd : 2'd0;
  assign RsAddr   = in_exec ? dec_rs : 2'd0;
  assign RegWrEn  = in_exec & dec_write;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: directed programs for the key
// scenarios followed by a random program with random memory wait states,
// all checked against an instruction-level reference model of the PC.
module tb_ctrl_sequencer;

  localparam int PC_W  = 10;
  localparam int DEPTH = 1 << PC_W;

  logic            Clk = 1'b0;
  logic            Reset;
  logic            Start;
  logic            ImemReq;
  logic [PC_W-1:0] ImemAddr;
  logic            ImemAck;
  logic [8:0]      ImemData;
  logic [3:0]      AluOp;
  logic [2:0]      AluIm;
  logic [1:0]      RdAddr;
  logic [1:0]      RsAddr;
  logic            AluBranch;
  logic            RegWrEn;
  logic [PC_W-1:0] Pc;
  logic            Done;

  logic [8:0] imem [DEPTH];
  int modelPc;
  int compareCount = 0;
  int mismatchCount = 0;

  ctrl_sequencer #(.PC_W(PC_W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .ImemReq   (ImemReq),
    .ImemAddr  (ImemAddr),
    .ImemAck   (ImemAck),
    .ImemData  (ImemData),
    .AluOp     (AluOp),
    .AluIm     (AluIm),
    .RdAddr    (RdAddr),
    .RsAddr    (RsAddr),
    .AluBranch (AluBranch),
    .RegWrEn   (RegWrEn),
    .Pc        (Pc),
    .Done      (Done)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Start pulse from IDLE/HALTED; DUT is in FETCH at the returned negedge.
  task automatic applyStimulus();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    modelPc = 0;
  endtask

  // Execute one instruction from FETCH: hold off the ack for 'waits' cycles,
  // check EXEC controls, then check the PC the model predicts.
  task automatic runInstr(input int waits, input logic br, output logic halted);
    logic [8:0] instr;
    int op, imm;
    instr = imem[modelPc];
    for (int w = 0; w <= waits; w++) begin
      checkOutput("fetch_req", ImemReq, 1);
      checkOutput("fetch_addr", ImemAddr, modelPc);
      checkOutput("fetch_done", Done, 0);
      checkOutput("fetch_wr", RegWrEn, 0);
      ImemAck  = (w == waits);
      ImemData = (w == waits) ? instr : 9'h1FF;
      @(negedge Clk);
    end
    ImemAck   = 1'b0;
    ImemData  = 9'h000;
    AluBranch = br;
    op  = int'(instr[8:5]);
    imm = int'(instr[2:0]);
    if (imm > 3) imm -= 8;
    checkOutput("exec_req", ImemReq, 0);
    checkOutput("exec_op", AluOp, op);
    checkOutput("exec_im", AluIm, instr[2:0]);
    checkOutput("exec_rd", RdAddr, instr[4:3]);
    checkOutput("exec_rs", RsAddr, instr[1:0]);
    checkOutput("exec_wr", RegWrEn, (op <= 9) ? 1 : 0);
    halted = (op == 15);
    if (op == 10 && br) modelPc = (modelPc + imm + DEPTH) % DEPTH;
    else if (!halted)   modelPc = (modelPc + 1) % DEPTH;
    @(negedge Clk);
    AluBranch = 1'b0;
    checkOutput("next_pc", Pc, modelPc);
    checkOutput("next_done", Done, halted ? 1 : 0);
    checkOutput("next_req", ImemReq, halted ? 0 : 1);
  endtask

  // While halted, an ack pulse must change nothing; then restart from 0.
  task automatic haltAndRestart();
    int heldPc;
    heldPc = modelPc;
    ImemAck = 1'b1;
    @(negedge Clk);
    ImemAck = 1'b0;
    @(negedge Clk);
    checkOutput("halt_done", Done, 1);
    checkOutput("halt_req", ImemReq, 0);
    checkOutput("halt_pc", Pc, heldPc);
    checkOutput("halt_wr", RegWrEn, 0);
    applyStimulus();
    checkOutput("restart_done", Done, 0);
  endtask

  initial begin
    logic h;
    Reset = 1'b0; Start = 1'b0; ImemAck = 1'b0; ImemData = '0; AluBranch = 1'b0;
    for (int i = 0; i < DEPTH; i++) imem[i] = 9'h000;
    #1;
    checkOutput("rst_req", ImemReq, 0);
    checkOutput("rst_done", Done, 0);
    checkOutput("rst_pc", Pc, 0);
    checkOutput("rst_addr", ImemAddr, 0);
    checkOutput("rst_wr", RegWrEn, 0);
    checkOutput("rst_op", AluOp, 0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    checkOutput("idle_req", ImemReq, 0);

    // Directed program: write, wait states, BNZ both ways, HALT at 2.
    imem[0] = 9'b0001_01_011;
    imem[1] = {4'd0, 2'd2, 3'b101};
    imem[2] = {4'd2, 2'd3, 3'b001};
    imem[3] = {4'd5, 2'd0, 3'b010};
    imem[4] = {4'd6, 2'd1, 3'b011};
    imem[5] = {4'd10, 2'd0, 3'b110};
    imem[6] = {4'd10, 2'd2, 3'b100};
    applyStimulus();
    runInstr(0, 1'b0, h);
    runInstr(3, 1'b0, h);
    runInstr(0, 1'b1, h);
    imem[2] = {4'hF, 5'b00000};
    runInstr(1, 1'b0, h);
    runInstr(0, 1'b0, h);
    runInstr(0, 1'b1, h);
    checkOutput("bnz_taken_pc", Pc, 3);
    runInstr(0, 1'b0, h);
    runInstr(2, 1'b0, h);
    runInstr(0, 1'b0, h);
    checkOutput("bnz_fall_pc", Pc, 6);
    runInstr(0, 1'b1, h);
    runInstr(0, 1'b0, h);
    checkOutput("halt_flag", h, 1);
    haltAndRestart();

    // Wrap-around: BNZ -4 from 1 to 1021, reserved op at 1023 wraps to 0.
    imem[0]    = {4'd0, 2'd1, 3'b010};
    imem[1]    = {4'd10, 2'd1, 3'b100};
    imem[1021] = {4'd8, 2'd3, 3'b001};
    imem[1022] = {4'd3, 2'd0, 3'b111};
    imem[1023] = {4'd12, 2'd2, 3'b110};
    runInstr(0, 1'b0, h);
    runInstr(1, 1'b1, h);
    checkOutput("wrap_neg_pc", Pc, 1021);
    runInstr(0, 1'b0, h);
    runInstr(0, 1'b0, h);
    runInstr(2, 1'b1, h);
    checkOutput("wrap_inc_pc", Pc, 0);
    runInstr(0, 1'b0, h);

    // Reset asserted mid-fetch at PC=1.
    checkOutput("midrst_req_before", ImemReq, 1);
    #1 Reset = 1'b0;
    #1;
    checkOutput("midrst_req", ImemReq, 0);
    checkOutput("midrst_pc", Pc, 0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    checkOutput("midrst_idle_req", ImemReq, 0);
    checkOutput("midrst_idle_done", Done, 0);

    // Random program with random waits and branch flags.
    for (int i = 0; i < DEPTH; i++) imem[i] = 9'($urandom_range(0, 511));
    applyStimulus();
    for (int n = 0; n < 400; n++) begin
      runInstr(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), h);
      if (h) haltAndRestart();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
